// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM states, NOP encoding and the
// instruction field offsets the hazard unit uses for its RS/RT compare.
package pipeline_pkg;

  localparam int INSTR_W = 32;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  // Instruction fetch is word-granular, so redirect targets drop their byte offset.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic [4:0] rs_of(input logic [INSTR_W-1:0] instr);
    return instr[RS_LSB +: 5];
  endfunction

  function automatic logic [4:0] rt_of(input logic [INSTR_W-1:0] instr);
    return instr[RT_LSB +: 5];
  endfunction

endpackage

// File: rtl/ifid_fetch_stage_sat_counter.sv
// Saturating event counter with synchronous reset; sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ifid_fetch_stage.sv
// MIPS fetch stage: owns the PC, picks the next fetch address and captures
// the fetched instruction into the IF/ID pipeline register.
module ifid_fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_hold,
  input  logic               ifid_hold,
  input  logic               ifid_flush,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  input  logic               jump_valid,
  input  logic [31:0]        jump_target,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [31:0]        pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [31:0]        ifid_pc4,
  output logic               ifid_valid,
  output logic [1:0]         fetch_state,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  logic [31:0]        pc_q, pc_d, pc_plus4;
  logic [INSTR_W-1:0] instr_q;
  logic [31:0]        pc4_q;
  logic               valid_q;
  fetch_state_e       state_q;
  logic               stall_inc, flush_inc;

  assign pc_plus4 = pc_q + 32'd4;

  // Redirects outrank pc_hold: the hazard unit raises hold alongside a flush.
  always_comb begin
    pc_d = pc_plus4;
    if (branch_taken)    pc_d = align_word(branch_target);
    else if (jump_valid) pc_d = align_word(jump_target);
    else if (pc_hold)    pc_d = pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  // IF/ID register and trace FSM share one priority chain: flush, hold, load.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      state_q <= RUN;
    end else if (ifid_flush) begin
      instr_q <= NOP;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      state_q <= FLUSH;
    end else if (ifid_hold) begin
      state_q <= STALL;
    end else begin
      instr_q <= imem_instr;
      pc4_q   <= pc_plus4;
      valid_q <= 1'b1;
      state_q <= RUN;
    end
  end

  // Only events that affect a real instruction are counted.
  assign stall_inc = ifid_hold & ~ifid_flush & valid_q;
  assign flush_inc = ifid_flush & valid_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (stall_inc),
    .count_o (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (flush_inc),
    .count_o (flush_cnt)
  );

  assign pc          = pc_q;
  assign ifid_instr  = instr_q;
  assign ifid_pc4    = pc4_q;
  assign ifid_valid  = valid_q;
  assign fetch_state = state_q;

endmodule
